instr_mem_loader: RTL and testbench

//  Write-side counterpart of the instruction memory: receives a byte stream (host/UART side),

---
 rtl/instr_mem_loader.sv | 123 ++++++++++++
 tb/tb_instr_mem_loader.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Byte-stream program loader: assembles little-endian 32-bit words into the
// instruction store and holds the core in reset until a load completes.
module instr_mem_loader #(
  parameter int ADDR_W    = 32,
  parameter int MAX_WORDS = 22,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [CNT_W-1:0]  load_count,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] load_q;
  logic [1:0]       byte_cnt;
  logic [23:0]      shift;
  logic             accept;
  logic             count_ok;
  logic             last_word;

  assign accept    = in_valid && in_ready;
  assign count_ok  = (load_count != '0) && (load_count <= CNT_W'(MAX_WORDS));
  assign last_word = (word_cnt + CNT_W'(1)) == load_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    wr_en      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (load_start && count_ok) state_next = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept && (byte_cnt == 2'd3)) state_next = WRITE;
      end
      WRITE: begin
        wr_en      = 1'b1;
        busy       = 1'b1;
        state_next = last_word ? DONE : LOAD;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath and pulse registers; wr_addr/wr_data are loaded together with the
  // 4th byte so they are already stable during the single WRITE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_cnt <= '0;
      load_q   <= '0;
      byte_cnt <= 2'd0;
      shift    <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      err      <= 1'b0;
      cpu_hold <= 1'b1;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            if (count_ok) begin
              load_q   <= load_count;
              word_cnt <= '0;
              byte_cnt <= 2'd0;
              cpu_hold <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            case (byte_cnt)
              2'd0: shift[7:0]   <= in_data;
              2'd1: shift[15:8]  <= in_data;
              2'd2: shift[23:16] <= in_data;
              default: begin
                wr_data <= {in_data, shift};
                wr_addr <= ADDR_W'({word_cnt, 2'b00});
              end
            endcase
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        WRITE: begin
          word_cnt <= word_cnt + CNT_W'(1);
          byte_cnt <= 2'd0;
        end
        DONE: cpu_hold <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: inputs change and outputs are read on
// the falling edge; a monitor logs every write strobe and pulse.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic [7:0]  load_count;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_hold;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int done_cnt = 0;
  int err_cnt  = 0;
  int rdy_viol = 0;

  always #5 clk = ~clk;

  instr_mem_loader #(.ADDR_W(32), .MAX_WORDS(22), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_count(load_count),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold)
  );

  always @(negedge clk) begin
    if (wr_en) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
      if (in_ready) rdy_viol++;
    end
    if (done) done_cnt++;
    if (err)  err_cnt++;
  end

  task automatic clear_log();
    wa.delete();
    wd.delete();
    done_cnt = 0;
    err_cnt  = 0;
    rdy_viol = 0;
  endtask

  task automatic start_load(input logic [7:0] n);
    load_count = n;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (t >= 50) begin
      miscompares++;
      $display("FAIL byte_accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, t);
    end
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int k = 0; k < 4; k++) begin
      if (maxgap > 0) begin
        int g;
        g = $urandom_range(maxgap, 0);
        if (g > 0) begin
          in_valid = 1'b0;
          repeat (g) @(negedge clk);
        end
      end
      send_byte(w[8*k +: 8]);
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done_cnt == 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (done_cnt == 0) begin
      miscompares++;
      $display("FAIL done_timeout: done_cnt=%0d, required 1", done_cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    load_start = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({cpu_hold, in_ready, wr_en, done, err, busy} !== 6'b100000) begin
      miscompares++;
      $display("FAIL reset_ctrl: hold,rdy,wen,done,err,busy=%b required 100000",
               {cpu_hold, in_ready, wr_en, done, err, busy});
    end
    vectors++;
    if (wr_addr !== 32'd0 || wr_data !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_data: addr=%h data=%h required 0/0", wr_addr, wr_data);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_bad_count();
    logic [7:0] bad [2];
    bad[0] = 8'd0;
    bad[1] = 8'd23;
    clear_log();
    for (int i = 0; i < 2; i++) begin
      start_load(bad[i]);
      vectors++;
      if (err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bad_count_err: cnt=%0d err=%b busy=%b rdy=%b required 1,0,0",
                 bad[i], err, busy, in_ready);
      end
      @(negedge clk);
      vectors++;
      if (err !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL bad_count_pulse: err=%b busy=%b required 0,0", err, busy);
      end
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (wa.size() != 0 || cpu_hold !== 1'b1 || err_cnt != 2) begin
      miscompares++;
      $display("FAIL bad_count_state: writes=%0d hold=%b errs=%0d required 0,1,2",
               wa.size(), cpu_hold, err_cnt);
    end
  endtask

  task automatic test_single();
    clear_log();
    start_load(8'd1);
    vectors++;
    if (in_ready !== 1'b1 || busy !== 1'b1 || cpu_hold !== 1'b1) begin
      miscompares++;
      $display("FAIL single_enter: rdy=%b busy=%b hold=%b required 1,1,1", in_ready, busy, cpu_hold);
    end
    send_byte(8'h33);
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'h00);
    in_valid = 1'b0;
    vectors++;
    if (wr_en !== 1'b1 || wr_addr !== 32'd0 || wr_data !== 32'h00050033 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL single_write: wen=%b addr=%h data=%h rdy=%b required 1,0,00050033,0",
               wr_en, wr_addr, wr_data, in_ready);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || wr_en !== 1'b0 || cpu_hold !== 1'b1) begin
      miscompares++;
      $display("FAIL single_done: done=%b busy=%b wen=%b hold=%b required 1,0,0,1",
               done, busy, wr_en, cpu_hold);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || cpu_hold !== 1'b0 || wr_data !== 32'h00050033) begin
      miscompares++;
      $display("FAIL single_after: done=%b hold=%b data=%h required 0,0,00050033",
               done, cpu_hold, wr_data);
    end
    vectors++;
    if (wa.size() != 1 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL single_count: writes=%0d dones=%0d required 1,1", wa.size(), done_cnt);
    end
  endtask

  task automatic test_random_valid();
    logic [31:0] w [3];
    w[0] = 32'h11223344;
    w[1] = 32'hA5A50F0F;
    w[2] = 32'hDEADBEEF;
    clear_log();
    start_load(8'd3);
    vectors++;
    if (cpu_hold !== 1'b1) begin
      miscompares++;
      $display("FAIL reload_hold: hold=%b required 1", cpu_hold);
    end
    for (int i = 0; i < 3; i++) send_word(w[i], 3);
    in_valid = 1'b0;
    wait_done();
    repeat (2) @(negedge clk);
    vectors++;
    if (wa.size() != 3) begin
      miscompares++;
      $display("FAIL rand_nwrites: writes=%0d required 3", wa.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (wa[i] !== 32'(4 * i) || wd[i] !== w[i]) begin
          miscompares++;
          $display("FAIL rand_word%0d: addr=%h data=%h required %h,%h", i, wa[i], wd[i], 4 * i, w[i]);
        end
      end
    end
    vectors++;
    if (rdy_viol != 0 || done_cnt != 1 || cpu_hold !== 1'b0) begin
      miscompares++;
      $display("FAIL rand_ctrl: rdy_on_write=%0d dones=%0d hold=%b required 0,1,0",
               rdy_viol, done_cnt, cpu_hold);
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    start_load(8'd4);
    send_word(32'h01234567, 0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || wr_en !== 1'b0 || cpu_hold !== 1'b1 || wr_addr !== 32'd0) begin
      miscompares++;
      $display("FAIL midreset_state: busy=%b wen=%b hold=%b addr=%h required 0,0,1,0",
               busy, wr_en, cpu_hold, wr_addr);
    end
    reset = 1'b0;
    repeat (6) @(negedge clk);
    vectors++;
    if (wa.size() != 1 || cpu_hold !== 1'b1 || done_cnt != 0) begin
      miscompares++;
      $display("FAIL midreset_partial: writes=%0d hold=%b dones=%0d required 1,1,0",
               wa.size(), cpu_hold, done_cnt);
    end
    start_load(8'd1);
    send_word(32'hCAFEF00D, 1);
    in_valid = 1'b0;
    wait_done();
    @(negedge clk);
    vectors++;
    if (wa.size() != 2 || wa[wa.size()-1] !== 32'd0 || wd[wd.size()-1] !== 32'hCAFEF00D) begin
      miscompares++;
      $display("FAIL midreset_fresh: writes=%0d last addr=%h data=%h required 2,0,cafef00d",
               wa.size(), wa[wa.size()-1], wd[wd.size()-1]);
    end
  endtask

  task automatic test_full();
    logic [31:0] w [22];
    for (int i = 0; i < 22; i++) w[i] = 32'h01020304 * (i + 1) ^ 32'h5A000000;
    clear_log();
    start_load(8'd22);
    for (int i = 0; i < 22; i++) begin
      send_word(w[i], 0);
      if (i == 5) begin
        in_valid = 1'b0;
        start_load(8'd1);
      end
    end
    in_valid = 1'b0;
    wait_done();
    repeat (2) @(negedge clk);
    vectors++;
    if (wa.size() != 22) begin
      miscompares++;
      $display("FAIL full_nwrites: writes=%0d required 22", wa.size());
    end else begin
      for (int i = 0; i < 22; i++) begin
        vectors++;
        if (wa[i] !== 32'(4 * i) || wd[i] !== w[i]) begin
          miscompares++;
          $display("FAIL full_word%0d: addr=%h data=%h required %h,%h", i, wa[i], wd[i], 4 * i, w[i]);
        end
      end
      vectors++;
      if (wa[21] !== 32'd84) begin
        miscompares++;
        $display("FAIL full_last_addr: addr=%0d required 84", wa[21]);
      end
    end
    vectors++;
    if (done_cnt != 1 || err_cnt != 0 || cpu_hold !== 1'b0 || rdy_viol != 0) begin
      miscompares++;
      $display("FAIL full_ctrl: dones=%0d errs=%0d hold=%b rdy_on_write=%0d required 1,0,0,0",
               done_cnt, err_cnt, cpu_hold, rdy_viol);
    end
  endtask

  initial begin
    reset = 1'b1;
    load_start = 1'b0;
    load_count = 8'd0;
    in_data = 8'd0;
    in_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_bad_count();
    test_single();
    test_random_valid();
    test_reset_mid();
    test_full();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
